// File: rtl/way_select_plru.sv
// way_select_plru: registered tag-match and replacement-victim selection.
// One lookup per cycle. The compare runs combinationally in the accept cycle and
// the result is registered. Per-set tree pseudo-LRU bits are stored in heap order.
//
// Handshake: a request is accepted when req_valid && req_ready. Here
// req_ready = !rsp_valid || rsp_ready, because there is a single output register
// and no skid buffer. A response is transferred when rsp_valid && rsp_ready.
// The response holds steady while rsp_valid && !rsp_ready.
module way_select_plru #(
    parameter int I_SIZE = 32,
    parameter int C_SIZE = 24,
    parameter int D_SIZE = 6,
    parameter int WAYS   = 8,
    parameter int PROT_W = 2,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = C_SIZE - D_SIZE - WAY_W,
    localparam int TAG_W = I_SIZE - C_SIZE + WAY_W,
    localparam int E_W   = PROT_W + TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SET_W-1:0]      req_set,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [WAYS*E_W-1:0]   req_ways,
    input  logic                  req_touch,
    input  logic                  plru_clr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_multi_hit,
    output logic [WAY_W-1:0]      rsp_way,
    output logic [PROT_W-1:0]     rsp_state,
    output logic [WAY_W-1:0]      rsp_victim,
    output logic [PROT_W-1:0]     rsp_victim_state
);

    localparam int SETS  = 1 << SET_W;
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0]  plru_mem [SETS];
    logic [NODES-1:0]  cur_bits;
    logic [NODES-1:0]  next_bits;

    logic [PROT_W-1:0] way_state [WAYS];
    logic [WAYS-1:0]   way_hit;
    logic [WAYS-1:0]   way_inv;

    logic              accept;
    logic              hit;
    logic              multi_hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  tree_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  touch_way;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign cur_bits  = plru_mem[req_set];

    // Unpack each way entry and form per-way hit and invalid flags.
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [TAG_W-1:0] way_tag;
        assign way_state[g] = req_ways[g*E_W+TAG_W +: PROT_W];
        assign way_tag      = req_ways[g*E_W +: TAG_W];
        assign way_hit[g]   = (way_state[g] != '0) && (way_tag == req_tag);
        assign way_inv[g]   = (way_state[g] == '0);
    end

    // Find the lowest-index hit, detect multiple hits, and find the lowest invalid way.
    always_comb begin
        hit       = 1'b0;
        multi_hit = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_hit[i]) begin
                if (hit) begin
                    multi_hit = 1'b1;
                end else begin
                    hit     = 1'b1;
                    hit_way = WAY_W'(i);
                end
            end
            if (way_inv[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    // Walk the tree from the root to find the victim: 0 selects the lower half, 1 the upper half.
    always_comb begin
        logic [WAY_W:0] node;
        logic           b;
        node     = '0;
        tree_way = '0;
        b        = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b        = cur_bits[node[WAY_W-1:0]];
            tree_way = (tree_way << 1) | WAY_W'(b);
            node     = {node[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(b);
        end
    end

    assign victim    = inv_found ? inv_way : tree_way;
    assign touch_way = hit ? hit_way : victim;

    // Point every node on the touched way's path away from it.
    always_comb begin
        logic [WAY_W:0]   node;
        logic [WAY_W-1:0] tw;
        logic             b;
        next_bits = cur_bits;
        node      = '0;
        tw        = touch_way;
        b         = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b                              = tw[WAY_W-1];
            tw                             = tw << 1;
            next_bits[node[WAY_W-1:0]]     = ~b;
            node = {node[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(b);
        end
    end

    // Output register: load on accept, drop on consume, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_multi_hit    <= 1'b0;
            rsp_way          <= '0;
            rsp_state        <= '0;
            rsp_victim       <= '0;
            rsp_victim_state <= '0;
        end else if (accept) begin
            rsp_valid        <= 1'b1;
            rsp_hit          <= hit;
            rsp_multi_hit    <= multi_hit;
            rsp_way          <= hit ? hit_way : victim;
            rsp_state        <= hit ? way_state[hit_way] : '0;
            rsp_victim       <= victim;
            rsp_victim_state <= way_state[victim];
        end else if (rsp_ready) begin
            rsp_valid        <= 1'b0;
        end
    end

    // PLRU storage: clear wins over a touch, and the touch is written at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n || plru_clr) begin
            for (int s = 0; s < SETS; s++) begin
                plru_mem[s] <= '0;
            end
        end else if (accept && req_touch) begin
            plru_mem[req_set] <= next_bits;
        end
    end

endmodule
